// File: rtl/note_player.sv
// note_player: square-wave tone generator for the song note bus (codes 1..96 = C0..B7).
// Defining NOTE_PLAYER_GAP_EN inserts GAP_CYCLES of silence between consecutive notes.
module note_player #(
  parameter int unsigned CLK_HZ     = 100_000_000,
  parameter int unsigned GAP_CYCLES = 5_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [6:0] note,
  output logic       audio,
  output logic       playing,
  output logic       note_change
);

  // state  | meaning
  // S_IDLE | silent; rest code or disabled
  // S_TONE | square wave running, toggles every hp cycles
  // S_GAP  | silence between two notes, GAP_CYCLES long (gap build only)
`ifdef NOTE_PLAYER_GAP_EN
  typedef enum logic [1:0] {S_IDLE, S_TONE, S_GAP} state_t;
  localparam logic [31:0] GAP_LAST = 32'(GAP_CYCLES - 1);
`else
  typedef enum logic [0:0] {S_IDLE, S_TONE} state_t;
`endif

  // Octave-0 half periods, C0..B0; ratio column is 2^((s-9)/12) so A0 is exact.
  localparam real HZ = real'(CLK_HZ);
  localparam logic [31:0] BASE_0  = 32'($rtoi(HZ / (55.0 * 0.5946035575) + 0.5));
  localparam logic [31:0] BASE_1  = 32'($rtoi(HZ / (55.0 * 0.6299605249) + 0.5));
  localparam logic [31:0] BASE_2  = 32'($rtoi(HZ / (55.0 * 0.6674199271) + 0.5));
  localparam logic [31:0] BASE_3  = 32'($rtoi(HZ / (55.0 * 0.7071067812) + 0.5));
  localparam logic [31:0] BASE_4  = 32'($rtoi(HZ / (55.0 * 0.7491535384) + 0.5));
  localparam logic [31:0] BASE_5  = 32'($rtoi(HZ / (55.0 * 0.7937005260) + 0.5));
  localparam logic [31:0] BASE_6  = 32'($rtoi(HZ / (55.0 * 0.8408964153) + 0.5));
  localparam logic [31:0] BASE_7  = 32'($rtoi(HZ / (55.0 * 0.8908987181) + 0.5));
  localparam logic [31:0] BASE_8  = 32'($rtoi(HZ / (55.0 * 0.9438743127) + 0.5));
  localparam logic [31:0] BASE_9  = 32'($rtoi(HZ / 55.0 + 0.5));
  localparam logic [31:0] BASE_10 = 32'($rtoi(HZ / (55.0 * 1.0594630944) + 0.5));
  localparam logic [31:0] BASE_11 = 32'($rtoi(HZ / (55.0 * 1.1224620483) + 0.5));

  state_t      r_state;
  logic [6:0]  r_cur_note;
  logic [31:0] r_hp;
  logic [31:0] r_cnt;
  logic        r_audio;
  logic        r_playing;
  logic        r_note_change;

  logic [6:0]  w_idx;
  logic [3:0]  w_semi;
  logic [2:0]  w_oct;
  logic [31:0] w_base;
  logic [31:0] w_shift;
  logic [31:0] w_hp_dec;
  logic        w_new_valid;
  logic        w_cur_valid;
  logic        w_change;

  state_t      w_nxt_state;
  logic [6:0]  w_nxt_cur;
  logic [31:0] w_nxt_hp;
  logic [31:0] w_nxt_cnt;
  logic        w_nxt_audio;
  logic        w_nxt_nc;

  assign w_new_valid = (note != 7'd0) && (note <= 7'd96);
  assign w_cur_valid = (r_cur_note != 7'd0) && (r_cur_note <= 7'd96);
  assign w_change    = (note != r_cur_note);
  assign w_idx       = note - 7'd1;
  assign w_semi      = 4'(w_idx % 7'd12);
  assign w_oct       = 3'(w_idx / 7'd12);

  always_comb begin
    case (w_semi)
      4'd0:    w_base = BASE_0;
      4'd1:    w_base = BASE_1;
      4'd2:    w_base = BASE_2;
      4'd3:    w_base = BASE_3;
      4'd4:    w_base = BASE_4;
      4'd5:    w_base = BASE_5;
      4'd6:    w_base = BASE_6;
      4'd7:    w_base = BASE_7;
      4'd8:    w_base = BASE_8;
      4'd9:    w_base = BASE_9;
      4'd10:   w_base = BASE_10;
      default: w_base = BASE_11;
    endcase
  end

  // Tiny simulation clocks can shift the high octaves to zero; keep at least one cycle.
  assign w_shift  = w_base >> w_oct;
  assign w_hp_dec = (w_shift == 32'd0) ? 32'd1 : w_shift;

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_cur   = r_cur_note;
    w_nxt_hp    = r_hp;
    w_nxt_cnt   = r_cnt;
    w_nxt_audio = r_audio;
    w_nxt_nc    = 1'b0;
    if (w_change) begin
      // A new code wins over any pending toggle; the old tone is dropped mid-cycle.
      w_nxt_cur   = note;
      w_nxt_hp    = w_hp_dec;
      w_nxt_cnt   = 32'd0;
      w_nxt_audio = 1'b0;
      w_nxt_nc    = enable;
      if (!enable || !w_new_valid) begin
        w_nxt_state = S_IDLE;
      end else begin
`ifdef NOTE_PLAYER_GAP_EN
        w_nxt_state = w_cur_valid ? S_GAP : S_TONE;
`else
        w_nxt_state = S_TONE;
`endif
      end
    end else if (!enable) begin
      w_nxt_state = S_IDLE;
      w_nxt_cnt   = 32'd0;
      w_nxt_audio = 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_cur_valid) begin
            w_nxt_state = S_TONE;
            w_nxt_cnt   = 32'd0;
            w_nxt_audio = 1'b0;
          end
        end
        S_TONE: begin
          if (r_cnt == r_hp - 32'd1) begin
            w_nxt_cnt   = 32'd0;
            w_nxt_audio = ~r_audio;
          end else begin
            w_nxt_cnt = r_cnt + 32'd1;
          end
        end
`ifdef NOTE_PLAYER_GAP_EN
        S_GAP: begin
          if (r_cnt == GAP_LAST) begin
            w_nxt_state = S_TONE;
            w_nxt_cnt   = 32'd0;
          end else begin
            w_nxt_cnt = r_cnt + 32'd1;
          end
        end
`endif
        default: begin
          w_nxt_state = S_IDLE;
          w_nxt_cnt   = 32'd0;
          w_nxt_audio = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_cur_note    <= 7'd0;
      r_hp          <= 32'd0;
      r_cnt         <= 32'd0;
      r_audio       <= 1'b0;
      r_playing     <= 1'b0;
      r_note_change <= 1'b0;
    end else begin
      r_state       <= w_nxt_state;
      r_cur_note    <= w_nxt_cur;
      r_hp          <= w_nxt_hp;
      r_cnt         <= w_nxt_cnt;
      r_audio       <= w_nxt_audio;
      r_playing     <= (w_nxt_state == S_TONE);
      r_note_change <= w_nxt_nc;
    end
  end

  assign audio       = r_audio;
  assign playing     = r_playing;
  assign note_change = r_note_change;

endmodule
